// File: rtl/memory_access.sv
// memory_access: MIPS MEM stage with byte/half/word data memory, MEM/WB register and debug read port
//
// Ports:
//   i_clk, i_reset            clock; synchronous active-low reset (memory contents kept)
//   i_halt                    freeze stage: no store, MEM/WB register holds
//   i_WB_write, i_WB_mem_to_reg, i_write_reg   write-back controls, registered through
//   i_MEM_read, i_MEM_write   load / store strobes
//   i_MEM_unsigned            1 zero-extend, 0 sign-extend sub-word loads
//   i_MEM_byte_half_word      00 byte, 01 half, 1x word
//   i_ALU_result              byte address for memory ops, ALU value otherwise
//   i_data_to_write_in_MEM    store data
//   i_debug_addr/o_debug_data combinational word read of the memory array
//   o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_read_data   MEM/WB register
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic               i_MEM_unsigned,
  input  logic [1:0]         i_MEM_byte_half_word,
  input  logic [NB_DATA-1:0] i_ALU_result,
  input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_read_data
);
  localparam int DEPTH = 2 ** NB_ADDR;
  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic [NB_DATA-1:0] rd_word, ld_data, st_mask, st_data;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [4:0]         sh;
  logic               st_en;
  logic               wb_write_q, wb_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic [NB_DATA-1:0] alu_result_q, alu_result_d;
  logic [NB_DATA-1:0] read_data_q, read_data_d;
  always_comb begin
    word_idx = i_ALU_result[NB_ADDR+1:2];
    lane     = i_ALU_result[1:0];
    rd_word  = mem_q[word_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = rd_word[{lane[1], 4'b0000} +: 16];
    ld_data  = i_MEM_byte_half_word == 2'b00
             ? (i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, rd_byte} : {{(NB_DATA-8){rd_byte[7]}}, rd_byte})
             : i_MEM_byte_half_word == 2'b01
             ? (i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, rd_half} : {{(NB_DATA-16){rd_half[15]}}, rd_half})
             : rd_word;
    // half stores ignore addr[0], so the shift is taken from addr[1] only
    sh       = i_MEM_byte_half_word == 2'b00 ? {lane, 3'b000} : {lane[1], 4'b0000};
    st_mask  = i_MEM_byte_half_word == 2'b00 ? {{(NB_DATA-8){1'b0}}, 8'hFF} << sh
             : i_MEM_byte_half_word == 2'b01 ? {{(NB_DATA-16){1'b0}}, 16'hFFFF} << sh
             : '1;
    st_data  = i_MEM_byte_half_word == 2'b00 ? {{(NB_DATA-8){1'b0}}, i_data_to_write_in_MEM[7:0]} << sh
             : i_MEM_byte_half_word == 2'b01 ? {{(NB_DATA-16){1'b0}}, i_data_to_write_in_MEM[15:0]} << sh
             : i_data_to_write_in_MEM;
    st_en        = i_reset & ~i_halt & i_MEM_write;
    wb_write_d   = i_WB_write;
    mem_to_reg_d = i_WB_mem_to_reg;
    write_reg_d  = i_write_reg;
    alu_result_d = i_ALU_result;
    read_data_d  = i_MEM_read ? ld_data : '0;
  end
  // read-modify-write keeps untouched lanes; load path sees the pre-store word
  always_ff @(posedge i_clk)
    if (st_en) mem_q[word_idx] <= (rd_word & ~st_mask) | (st_data & st_mask);
  always_ff @(posedge i_clk)
    if (!i_reset) begin
      wb_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else if (!i_halt) begin
      wb_write_q   <= wb_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  assign o_debug_data    = mem_q[i_debug_addr];
  assign o_WB_write      = wb_write_q;
  assign o_WB_mem_to_reg = mem_to_reg_q;
  assign o_write_reg     = write_reg_q;
  assign o_ALU_result    = alu_result_q;
  assign o_read_data     = read_data_q;
endmodule
